// File: rtl/huff_mask_scanner.sv
// rtl/huff_mask_scanner.sv - streams set-bit indices of a 128-bit mask, highest first.
// Optional HUFF_SCAN_COUNT_EN compiles in the per-mask index counter behind done_count.

module encoder #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 7
) (
  input  logic [DATA_W-1:0] data_in,
  output logic [IDX_W-1:0]  index_out
);
  // Ascending scan so the highest set bit is the last assignment to win.
  always_comb begin
    index_out = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_in[i]) index_out = IDX_W'(i);
    end
  end
endmodule

module huff_mask_scanner #(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mask,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              done,
  output logic [CNT_W-1:0]  done_count
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  enc_idx;
  logic [DATA_W-1:0] onehot;
  logic [DATA_W-1:0] rest;

  encoder #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_enc (
    .data_in  (work_q),
    .index_out(enc_idx)
  );

  assign onehot    = DATA_W'(1) << enc_idx;
  assign rest      = work_q & ~onehot;
  assign out_valid = (state_q == SCAN);
  assign out_index = out_valid ? enc_idx : '0;
  assign out_last  = out_valid && (rest == '0);
  assign in_ready  = rst_n && !abort && (state_q == IDLE);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      work_d  = '0;
    end else if (state_q == IDLE) begin
      if (in_valid && in_ready) begin
        work_d = in_mask;
        if (~|in_mask) done_d = 1'b1;
        else           state_d = SCAN;
      end
    end else if (out_ready) begin
      work_d = rest;
      if (out_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      done_q  <= done_d;
    end
  end

`ifdef HUFF_SCAN_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;

  always_comb begin
    cnt_d        = cnt_q;
    done_count_d = '0;
    if (abort || (in_valid && in_ready)) begin
      cnt_d = '0;
    end else if (out_valid && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (out_last) done_count_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      done_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      done_count_q <= done_count_d;
    end
  end

  assign done_count = done_count_q;
`else
  assign done_count = '0;
`endif
endmodule

// File: doc/huff_mask_scanner.md
# huff_mask_scanner

Sequencer wrapped around the team's 128-to-7 `encoder` block in the Huffman accelerator. It accepts a 128-bit symbol-presence mask and iteratively drives the remaining bits through `encoder`. It emits every set-bit index, highest first, as a valid/ready stream, clearing each bit as it is consumed. Downstream Huffman tree and code-table builders consume the stream to learn which symbols are present and how many.

## Interface
- `DATA_W`, 128: mask width. Only 128 is supported, to match `encoder`.
- `IDX_W`, 7: index width. This is the `encoder` output width.
- `CNT_W`, 8: count width. It holds 0..128.

- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: a mask is offered.
- `in_ready` out 1: the scanner can accept a mask.
- `in_mask` in DATA_W: the symbol-presence mask. Bit i set means symbol i is present.
- `abort` in 1: synchronous abort of the current scan.
- `out_valid` out 1: `out_index` is valid.
- `out_ready` in 1: the consumer accepts `out_index`.
- `out_index` out IDX_W: index of the highest remaining set bit.
- `out_last` out 1: the current index is the final one of this mask.
- `done` out 1: one-cycle pulse when a mask has been fully scanned.
- `done_count` out CNT_W: number of indices emitted for the finished mask. Valid while `done`=1.

## Operation
- State register `work[127:0]`, FSM {IDLE, SCAN}, counter `cnt[CNT_W-1:0]`.
- `encoder` contract: the combinational output is the index of the highest-order set bit of its input, and 0 for an all-zero input. The scanner detects the empty case with its own OR-reduction and never relies on encoder output 0.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `work`<=`in_mask`, `cnt`<=0.
  - If `in_mask`==0, stay in IDLE and pulse `done` next cycle with `done_count`=0.
  - Otherwise go to SCAN.
- SCAN:
  - `out_valid`=1 and `out_index`=encoder(`work`).
  - `out_last`=1 when (`work` & ~onehot(`out_index`))==0.
  - On `out_valid`&&`out_ready`: clear bit `out_index` in `work` and increment `cnt`.
  - If `out_last`: go to IDLE and pulse `done` next cycle with `done_count`=`cnt`+1.
- Backpressure: while `out_ready`=0, `out_index`/`out_last`/`out_valid` hold stable and `work` is unchanged.
- `abort`=1, in any state: next cycle state=IDLE, `work`=0, `cnt`=0, no `done` pulse.
  - `abort` wins over a simultaneous transfer or load.
  - An `in_valid` presented in the same cycle as `abort` is not accepted. `in_ready` is forced to 0 in that cycle.
- Index order is strictly descending. Each set bit is emitted exactly once.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - State IDLE; `work`, `cnt` = 0.
  - `out_valid`=0, `out_index`=0, `out_last`=0, `done`=0, `done_count`=0.
  - `in_ready`=0 while `rst_n` is low and 1 from the first cycle after release.
  - Reset mid-scan discards the mask with no `done`.
- Latency and throughput:
  - Mask accepted at edge T gives first `out_valid` in cycle T+1.
  - With `out_ready` held high, one index per cycle. N set bits finish transferring at edge T+N.
  - `done` is high in cycle T+N+1, with `in_ready`=1 in the same cycle, so back-to-back masks are legal.
  - Total N+1 cycles per non-empty mask.
  - Empty mask: `done` is high in cycle T+1 and `out_valid` never rises.
- `out_index` is combinational from `work`. The encoder path is the critical path and is unregistered.
- `done` is registered and lasts exactly one cycle. `done_count` is 0 whenever `done`=0.

## Configuration
- `HUFF_SCAN_COUNT_EN` defined:
  - `cnt` and `done_count` logic is compiled in as specified.
- `HUFF_SCAN_COUNT_EN` undefined:
  - `cnt` is removed and `done_count` is tied to 0.
  - `done`, the stream and all timing are unchanged.

## Test plan
- Mask 128'b100111010101, `out_ready`=1: indices 11,8,7,6,4,2,0 on consecutive cycles. `out_last` is set only on 0. `done` follows one cycle later with `done_count`=7 (0 without the macro).
- Mask 64'h5555_5555_5555_5555 (upper 64 bits zero): 32 indices 62,60,…,0. `done_count`=32. First `out_valid` is one cycle after acceptance.
- Mask 0: no `out_valid`. `done`=1 next cycle with `done_count`=0. `in_ready`=1 throughout.
- Mask all-ones, `out_ready` toggling 1,0,1,0: 128 indices 127..0, each held stable across stall cycles. `done_count`=128. Check 8-bit count with no wrap.
- Mask 128'b1011 with `abort` pulsed after the first transfer (index 3): IDLE next cycle, no further indices, no `done`. A new mask 128'b1 then yields index 0 with `out_last`=1 and `done_count`=1.
- `rst_n` low for one cycle mid-scan of the all-ones mask: all outputs 0 next cycle, no `done`, `in_ready`=1 the cycle after release.
